// File: rtl/lane_position_fsm.sv
// Lane tracker that synchronises and debounces the raw left/right keys, then moves CurrPos by one lane per committed move.
// A raw key edge reaches dbX after 2+DEBOUNCE_CYCLES cycles; a pending move waits in COMMIT until DoneDrawing is high.
module lane_position_fsm #(
   parameter int NUM_LANES       = 4,
   parameter int POS_W           = 4,
   parameter int START_LANE      = 0,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_RATE     = 8,
   parameter int CNT_W           = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             LeftIn,
   input  logic             RightIn,
   input  logic             Enable,
   input  logic             DoneDrawing,
   output logic [POS_W-1:0] CurrPos,
   output logic [POS_W-1:0] PrevPos,
   output logic             Moving,
   output logic             MoveDir,
   output logic             MovePulse
);

   typedef enum logic [2:0] {IDLE, HELD_L, HELD_R, COMMIT, WAIT_REL} stateT;

   localparam logic [POS_W-1:0] LastLane  = POS_W'(NUM_LANES - 1);
   localparam logic [POS_W-1:0] StartPos  = POS_W'(START_LANE);
   localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);
   localparam bit               RepeatOn  = (REPEAT_DELAY > 0);

   // Index 0 is the left key, index 1 the right key.
   logic [1:0]       syncA;
   logic [1:0]       syncB;
   logic [1:0]       dbKey;
   logic [CNT_W-1:0] dbCnt [2];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         syncA <= '0;
         syncB <= '0;
         dbKey <= '0;
         for (int k = 0; k < 2; k++) dbCnt[k] <= '0;
      end else begin
         syncA <= {RightIn, LeftIn};
         syncB <= syncA;
         for (int k = 0; k < 2; k++) begin
            if (syncB[k] == dbKey[k]) begin
               dbCnt[k] <= '0;
            end else if (dbCnt[k] == DebLast) begin
               dbKey[k] <= ~dbKey[k];
               dbCnt[k] <= '0;
            end else begin
               dbCnt[k] <= dbCnt[k] + CNT_W'(1);
            end
         end
      end
   end

   logic             dbL;
   logic             dbR;
   logic             heldKey;
   logic             otherKey;
   logic             targetAtWall;
   logic             repeatHit;
   stateT            state;
   logic [POS_W-1:0] target;
   logic [CNT_W-1:0] rptCnt;
   logic             firstRpt;

   assign dbL          = dbKey[0];
   assign dbR          = dbKey[1];
   assign heldKey      = MoveDir ? dbR : dbL;
   assign otherKey     = MoveDir ? dbL : dbR;
   assign targetAtWall = MoveDir ? (target == LastLane) : (target == '0);
   // The first auto-repeat waits REPEAT_DELAY cycles, later ones REPEAT_RATE.
   assign repeatHit    = RepeatOn && (rptCnt == (firstRpt ? DelayLast : RateLast));

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         CurrPos   <= StartPos;
         PrevPos   <= StartPos;
         target    <= StartPos;
         rptCnt    <= '0;
         firstRpt  <= 1'b0;
         Moving    <= 1'b0;
         MoveDir   <= 1'b0;
         MovePulse <= 1'b0;
      end else begin
         MovePulse <= 1'b0;
         case (state)
            IDLE: begin
               if (Enable && dbR && !dbL && CurrPos != LastLane) begin
                  state    <= HELD_R;
                  MoveDir  <= 1'b1;
                  Moving   <= 1'b1;
                  rptCnt   <= '0;
                  firstRpt <= 1'b1;
               end else if (Enable && dbL && !dbR && CurrPos != '0) begin
                  state    <= HELD_L;
                  MoveDir  <= 1'b0;
                  Moving   <= 1'b1;
                  rptCnt   <= '0;
                  firstRpt <= 1'b1;
               end else if (dbL && dbR) begin
                  state  <= WAIT_REL;
                  Moving <= 1'b1;
               end
            end
            HELD_L, HELD_R: begin
               if (otherKey) begin
                  state <= WAIT_REL;
               end else if (!heldKey || repeatHit) begin
                  state  <= COMMIT;
                  target <= MoveDir ? CurrPos + POS_W'(1) : CurrPos - POS_W'(1);
               end else if (RepeatOn) begin
                  rptCnt <= rptCnt + CNT_W'(1);
               end
            end
            COMMIT: begin
               if (DoneDrawing) begin
                  PrevPos   <= CurrPos;
                  CurrPos   <= target;
                  MovePulse <= 1'b1;
                  if (heldKey && !targetAtWall && RepeatOn) begin
                     state    <= MoveDir ? HELD_R : HELD_L;
                     rptCnt   <= '0;
                     firstRpt <= 1'b0;
                  end else if (heldKey) begin
                     state <= WAIT_REL;
                  end else begin
                     state  <= IDLE;
                     Moving <= 1'b0;
                  end
               end
            end
            WAIT_REL: begin
               if (!dbL && !dbR) begin
                  state  <= IDLE;
                  Moving <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               Moving <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lane_position_fsm.sv
// Bench for lane_position_fsm: a single-step instance and an auto-repeat instance,
// directed scenarios followed by random press/glitch events against a lane-count model.
`timescale 1ns/1ps
module tb_lane_position_fsm;

   logic       Clock;
   logic       Reset;
   logic       Enable;
   logic       DoneDrawing;
   logic       lA, rA, lB, rB;
   logic [3:0] currA, prevA, currB, prevB;
   logic       movA, dirA, pulA, movB, dirB, pulB;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pulsesA = 0;
   int pulsesB = 0;
   int lastPulA = -1;
   int pulCycB[$];
   bit pulAd = 0;
   bit pulBd = 0;
   bit randDone = 0;

   int expPulA, expPulB, relCyc, doneCyc, minGap;
   int posA, prvA, posB, prvB, kind, len, en;
   bit sawMove;

   lane_position_fsm #(
      .NUM_LANES(4), .POS_W(4), .START_LANE(0), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(0), .REPEAT_RATE(8), .CNT_W(16)
   ) dutA (
      .Clock(Clock), .Reset(Reset), .LeftIn(lA), .RightIn(rA), .Enable(Enable),
      .DoneDrawing(DoneDrawing), .CurrPos(currA), .PrevPos(prevA), .Moving(movA),
      .MoveDir(dirA), .MovePulse(pulA)
   );

   lane_position_fsm #(
      .NUM_LANES(4), .POS_W(4), .START_LANE(2), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10), .REPEAT_RATE(5), .CNT_W(16)
   ) dutB (
      .Clock(Clock), .Reset(Reset), .LeftIn(lB), .RightIn(rB), .Enable(Enable),
      .DoneDrawing(DoneDrawing), .CurrPos(currB), .PrevPos(prevB), .Moving(movB),
      .MoveDir(dirB), .MovePulse(pulB)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(negedge Clock);
         if (randDone) DoneDrawing = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Pulse monitor: counts strobes and insists they are never back to back.
   always @(negedge Clock) begin
      if (pulAd) check("pulseA_gap", pulA, 0);
      if (pulBd) check("pulseB_gap", pulB, 0);
      if (pulA === 1'b1) begin
         pulsesA  <= pulsesA + 1;
         lastPulA <= cyc;
      end
      if (pulB === 1'b1) begin
         pulsesB <= pulsesB + 1;
         pulCycB.push_back(cyc);
      end
      pulAd <= (pulA === 1'b1);
      pulBd <= (pulB === 1'b1);
   end

   initial begin
      Reset = 1'b0; Enable = 1'b1; DoneDrawing = 1'b1;
      lA = 0; rA = 0; lB = 0; rB = 0;
      expPulA = 0; expPulB = 0;
      tick(3);
      check("rst_currA", currA, 0);
      check("rst_prevA", prevA, 0);
      check("rst_movA", movA, 0);
      check("rst_dirA", dirA, 0);
      check("rst_pulA", pulA, 0);
      check("rst_currB", currB, 2);
      check("rst_prevB", prevB, 2);
      check("rst_movB", movB, 0);
      Reset = 1'b1;
      tick(5);

      // Single press and release: one move, fixed latency from the release edge.
      rA = 1; tick(20); rA = 0; relCyc = cyc; tick(25);
      expPulA = 1;
      check("basic_pulses", pulsesA, expPulA);
      check("basic_latency", lastPulA - relCyc, 8);
      check("basic_curr", currA, 1);
      check("basic_prev", prevA, 0);
      check("basic_moving", movA, 0);

      // Bounce shorter than the debounce window never starts a move.
      sawMove = 0;
      for (int i = 0; i < 15; i++) begin
         rA = ~rA; tick(2);
         if (movA) sawMove = 1;
      end
      rA = 0; tick(20);
      check("bounce_moving", sawMove, 0);
      check("bounce_curr", currA, 1);
      check("bounce_pulses", pulsesA, expPulA);

      repeat (2) begin
         rA = 1; tick(10); rA = 0; tick(25);
      end
      expPulA += 2;
      check("walk_curr", currA, 3);
      check("walk_prev", prevA, 2);

      rA = 1; tick(15);
      check("wallR_moving", movA, 0);
      rA = 0; tick(20);
      check("wallR_curr", currA, 3);
      check("wallR_pulses", pulsesA, expPulA);

      // Opposite key cancels the held move.
      lA = 1; tick(10);
      check("cancel_held", movA, 1);
      check("cancel_dir", dirA, 0);
      rA = 1; tick(10);
      check("cancel_wait", movA, 1);
      lA = 0; tick(15);
      check("cancel_wait_one", movA, 1);
      rA = 0; tick(15);
      check("cancel_idle", movA, 0);
      check("cancel_curr", currA, 3);
      check("cancel_pulses", pulsesA, expPulA);

      // Commit stalls while the renderer is busy.
      DoneDrawing = 0;
      lA = 1; tick(10); lA = 0; tick(12);
      check("hs_hold_curr", currA, 3);
      check("hs_hold_moving", movA, 1);
      check("hs_hold_pulses", pulsesA, expPulA);
      tick(8);
      DoneDrawing = 1; doneCyc = cyc; tick(3);
      expPulA++;
      check("hs_pulses", pulsesA, expPulA);
      check("hs_latency", lastPulA - doneCyc, 1);
      check("hs_curr", currA, 2);
      check("hs_prev", prevA, 3);
      check("hs_moving", movA, 0);

      Enable = 0;
      rA = 1; tick(15);
      check("en_moving", movA, 0);
      rA = 0; tick(20);
      check("en_curr", currA, 2);
      check("en_pulses", pulsesA, expPulA);
      Enable = 1;

      // Auto-repeat: hold left from lane 2 down to the wall.
      lB = 1; tick(40);
      expPulB = 2;
      check("rptL_curr", currB, 0);
      check("rptL_prev", prevB, 1);
      check("rptL_wait", movB, 1);
      check("rptL_pulses", pulsesB, expPulB);
      lB = 0; tick(20);
      check("rptL_idle", movB, 0);

      lB = 1; tick(15);
      check("wallL_moving", movB, 0);
      lB = 0; tick(20);
      check("wallL_curr", currB, 0);
      check("wallL_pulses", pulsesB, expPulB);

      pulCycB.delete();
      rB = 1; tick(40);
      expPulB += 3;
      check("rptR_curr", currB, 3);
      check("rptR_prev", prevB, 2);
      check("rptR_wait", movB, 1);
      check("rptR_dir", dirB, 1);
      check("rptR_pulses", pulsesB, expPulB);
      check("rptR_count", pulCycB.size(), 3);
      minGap = 1000;
      for (int i = 1; i < pulCycB.size(); i++)
         if (pulCycB[i] - pulCycB[i-1] < minGap) minGap = pulCycB[i] - pulCycB[i-1];
      check("rptR_gap_ge5", (minGap >= 5), 1);
      rB = 0; tick(20);
      check("rptR_idle", movB, 0);

      // Reset in the middle of a held move.
      Reset = 0; tick(2); Reset = 1; tick(3);
      check("rst2_currA", currA, 0);
      check("rst2_currB", currB, 2);
      rB = 1; tick(10);
      check("rstmid_held", movB, 1);
      check("rstmid_dir", dirB, 1);
      Reset = 0; #1;
      check("rstmid_curr", currB, 2);
      check("rstmid_prev", prevB, 2);
      check("rstmid_moving", movB, 0);
      check("rstmid_dir0", dirB, 0);
      rB = 0; tick(3); Reset = 1; tick(30);
      check("rstmid_pulses", pulsesB, expPulB);
      check("rstmid_curr_after", currB, 2);
      check("rstmid_idle", movB, 0);

      // Random single presses, glitches and double presses against a lane model.
      posA = 0; prvA = 0; posB = 2; prvB = 2;
      for (int ev = 0; ev < 40; ev++) begin
         kind = $urandom_range(0, 3);
         en   = ($urandom_range(0, 4) != 0);
         len  = $urandom_range(5, 8);
         Enable = en[0];
         randDone = 1;
         tick(2);
         case (kind)
            0: begin
               rA = 1; rB = 1; tick(len); rA = 0; rB = 0;
               if (en != 0 && posA < 3) begin prvA = posA; posA++; expPulA++; end
               if (en != 0 && posB < 3) begin prvB = posB; posB++; expPulB++; end
            end
            1: begin
               lA = 1; lB = 1; tick(len); lA = 0; lB = 0;
               if (en != 0 && posA > 0) begin prvA = posA; posA--; expPulA++; end
               if (en != 0 && posB > 0) begin prvB = posB; posB--; expPulB++; end
            end
            2: begin
               len = $urandom_range(1, 2);
               if ($urandom_range(0, 1) == 1) begin
                  rA = 1; rB = 1; tick(len); rA = 0; rB = 0;
               end else begin
                  lA = 1; lB = 1; tick(len); lA = 0; lB = 0;
               end
            end
            default: begin
               lA = 1; lB = 1; rA = 1; rB = 1; tick(len);
               lA = 0; lB = 0; rA = 0; rB = 0;
            end
         endcase
         tick(30);
         randDone = 0; DoneDrawing = 1; tick(3);
         check("rnd_currA", currA, posA);
         check("rnd_prevA", prevA, prvA);
         check("rnd_currB", currB, posB);
         check("rnd_prevB", prevB, prvB);
         check("rnd_pulsesA", pulsesA, expPulA);
         check("rnd_pulsesB", pulsesB, expPulB);
         check("rnd_idleA", movA, 0);
      end
      Enable = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_position_fsm.md
Name: lane_position_fsm

Overview:
- Parametrised successor to the player-character lane FSM. Tracks the character's lane across NUM_LANES horizontal positions, driven by raw LeftIn/RightIn keys.
- Adds internal synchronise+debounce, optional hold-to-auto-repeat, opposite-key cancel, and a commit handshake with the renderer through DoneDrawing.
- Sits between the key inputs and the draw/erase datapath. The renderer reads CurrPos/PrevPos and acts on MovePulse.

Parameters:
- NUM_LANES, 4, number of lanes (2..16); lane 0 is the leftmost.
- POS_W, 4, width of the position outputs; must satisfy 2^POS_W >= NUM_LANES.
- START_LANE, 0, lane loaded on reset; must be < NUM_LANES.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to change a debounced level (>=1).
- REPEAT_DELAY, 0, hold cycles before the first auto-repeat move; 0 disables auto-repeat.
- REPEAT_RATE, 8, hold cycles between subsequent auto-repeat moves (>=1).
- CNT_W, 16, width of the debounce and repeat counters.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LeftIn  in  1  raw left key, active-high, asynchronous to Clock.
- RightIn  in  1  raw right key, active-high, asynchronous to Clock.
- Enable  in  1  when low, new presses are ignored in IDLE; moves already in flight complete.
- DoneDrawing  in  1  renderer ready; a pending move commits only on a cycle where this is high.
- CurrPos  out  POS_W  current lane.
- PrevPos  out  POS_W  lane before the most recent committed move.
- Moving  out  1  high in every state except IDLE.
- MoveDir  out  1  direction of the held or pending move: 1 = right, 0 = left.
- MovePulse  out  1  one-cycle strobe on the cycle after each commit.

Behaviour:
- Reset (async, Reset=0):
  - State=IDLE; CurrPos=PrevPos=START_LANE.
  - Moving=MoveDir=MovePulse=0.
  - Synchronisers, debounced levels dbL/dbR, and all counters cleared to 0.
  - Deassertion mid-operation resumes from IDLE; no partial move is ever committed.
- Input conditioning, per key:
  - 2-flop synchroniser, then debounce counter.
  - dbX toggles on the edge where the synchronised input has differed from dbX for DEBOUNCE_CYCLES consecutive cycles.
  - Any sample equal to dbX clears the counter.
- States: IDLE, HELD_L, HELD_R, COMMIT, WAIT_REL.
- IDLE:
  - Enable=1, dbR=1, dbL=0, CurrPos<NUM_LANES-1 -> HELD_R, MoveDir=1.
  - Enable=1, dbL=1, dbR=0, CurrPos>0 -> HELD_L, MoveDir=0.
  - dbL=dbR=1 -> WAIT_REL.
  - Press toward a wall (left at lane 0, right at NUM_LANES-1) -> stay IDLE, no outputs change.
  - Entering HELD_x clears the repeat counter.
- HELD_R (HELD_L mirrors it):
  - dbR falls -> COMMIT, target=CurrPos+1.
  - dbL rises while in HELD_R -> cancel, go to WAIT_REL, no move.
  - If REPEAT_DELAY>0, the repeat counter increments each cycle. Reaching REPEAT_DELAY (first move) or REPEAT_RATE (later moves) -> COMMIT with the key still held.
- COMMIT:
  - Holds target until DoneDrawing=1.
  - On that edge: PrevPos<=CurrPos, CurrPos<=target, MovePulse=1 in the following cycle.
  - Next state: if the key is still held, the new CurrPos is not at the wall in MoveDir, and REPEAT_DELAY>0 -> HELD_x with the counter cleared and the REPEAT_RATE threshold in force. Otherwise, if the key is still held -> WAIT_REL. Otherwise -> IDLE.
  - Key edges during COMMIT do not abort the commit.
- WAIT_REL: stays until dbL=dbR=0, then -> IDLE. Prevents a double move from a single press.
- Latency:
  - Raw edge to dbX change: 2 + DEBOUNCE_CYCLES cycles.
  - dbX edge to state change: 1 cycle.
  - COMMIT with DoneDrawing=1 to CurrPos update: 1 cycle.
- Position arithmetic is unsigned POS_W bits. CurrPos never leaves [0, NUM_LANES-1]; no wrap-around at either end.
- At most one move per commit; MovePulse never asserts on two consecutive cycles.

Test Plan:
- Reset check: NUM_LANES=4, START_LANE=2. Assert Reset mid-HELD_R -> CurrPos=PrevPos=2, Moving=0 immediately (async), no MovePulse after release of reset.
- Basic move: DEBOUNCE_CYCLES=4, DoneDrawing=1, REPEAT_DELAY=0. Press RightIn for 20 cycles then release -> exactly one MovePulse, CurrPos 0->1, PrevPos=0; pulse appears 2+4+1+1 cycles after the raw release edge.
- Bounce and wall: toggle RightIn every 2 cycles for 30 cycles -> no state change. At CurrPos=3 press RightIn -> no move. At CurrPos=0 press LeftIn -> no move.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_RATE=5. Hold RightIn from lane 0 for 40 cycles -> moves to 1, 2, 3, stops at 3 with state WAIT_REL; three MovePulses total, spaced by at least 5 cycles.
- Cancel: in HELD_R, press LeftIn as well -> no move, WAIT_REL until both keys are released, then IDLE with CurrPos unchanged.
- Handshake: DoneDrawing=0 for 12 cycles after release -> CurrPos holds. Raise DoneDrawing -> commit on that edge, MovePulse 1 cycle later. Enable=0 with a press in IDLE -> ignored.
